// File: rtl/d0fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d0fifo_pkg
//  Description : Shared helpers and types for the delay-0 RAM FIFO controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package d0fifo_pkg;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int size);
        return $clog2(size) + 1;
    endfunction

    // Status flags derived from pointers and registered occupancy.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/d0fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : d0fifo_ctrl_if
//  Description : Push/pop handshake and RAM port bundle for d0fifo_ctrl.
//                master = controller side, slave = producer/consumer/RAM side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface d0fifo_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 32
);
    localparam int c_AW = $clog2(SIZE);

    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic               ram_wen;
    logic [c_AW-1:0]    ram_waddr;
    logic [WIDTH-1:0]   ram_wdata;
    logic               ram_ren;
    logic [c_AW-1:0]    ram_raddr;
    logic [WIDTH-1:0]   ram_rdata;

    modport master (
        input  in_valid, in_data, out_ready, ram_rdata,
        output in_ready, out_valid, out_data,
               ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr
    );

    modport slave (
        output in_valid, in_data, out_ready, ram_rdata,
        input  in_ready, out_valid, out_data,
               ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr
    );
endinterface
`default_nettype wire

// File: rtl/d0fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : d0fifo_ptr
//  Description : Wrap-bit FIFO pointer ($clog2(SIZE)+1 bits) with increment,
//                synchronous flush and synchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module d0fifo_ptr
    import d0fifo_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_flush,
    input  wire logic                 i_inc,
    output logic [$clog2(SIZE):0]     o_ptr
);
    localparam int c_PTR_W = ptr_width(SIZE);

    logic [c_PTR_W-1:0] r_ptr;

    // Pointer register; the MSB toggles naturally on index wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_flush) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + c_PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/d0fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : d0fifo_ctrl
//  Description : Show-ahead FIFO controller for an external delay-0 RAM
//                (1-cycle write, combinational read). Tracks occupancy,
//                thresholds and a high-water mark.
//  Revision    : 1.0 - initial release
// ============================================================================
module d0fifo_ctrl
    import d0fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SIZE     = 32,
    parameter int AF_LEVEL = SIZE - 2,
    parameter int AE_LEVEL = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 flush,
    input  wire logic                 hwm_clr,
    d0fifo_ctrl_if.master             bus,
    output logic [$clog2(SIZE):0]     count,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(SIZE):0]     high_water
);
    localparam int c_AW    = $clog2(SIZE);
    localparam int c_PTR_W = ptr_width(SIZE);

    logic [c_PTR_W-1:0] w_wr_ptr;
    logic [c_PTR_W-1:0] w_rd_ptr;
    logic [c_PTR_W-1:0] r_count;
    logic [c_PTR_W-1:0] w_count_nxt;
    logic [c_PTR_W-1:0] r_high_water;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_head;
    fifo_status_t       w_status;

    // Handshake qualification: full blocks push, empty blocks pop.
    assign w_push = bus.in_valid  & ~w_status.full;
    assign w_pop  = bus.out_ready & ~w_status.empty;

    d0fifo_ptr #(.SIZE(SIZE)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_inc   (w_push),
        .o_ptr   (w_wr_ptr)
    );

    d0fifo_ptr #(.SIZE(SIZE)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_inc   (w_pop),
        .o_ptr   (w_rd_ptr)
    );

    // Status flags: empty/full from pointers, thresholds from registered count.
    always_comb begin
        w_status              = '0;
        w_status.empty        = (w_wr_ptr == w_rd_ptr);
        w_status.full         = (w_wr_ptr[c_AW-1:0] == w_rd_ptr[c_AW-1:0]) &&
                                (w_wr_ptr[c_AW] != w_rd_ptr[c_AW]);
        w_status.almost_full  = (r_count >= c_PTR_W'(AF_LEVEL));
        w_status.almost_empty = (r_count <= c_PTR_W'(AE_LEVEL));
    end

    // Next occupancy; a flush empties the FIFO and drops that cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count + c_PTR_W'(w_push) - c_PTR_W'(w_pop);
        if (flush) begin
            w_count_nxt = '0;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // High-water mark: held over flush, reloaded by hwm_clr, else running max.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_high_water <= '0;
        end else if (flush) begin
            r_high_water <= r_high_water;
        end else if (hwm_clr) begin
            r_high_water <= r_count;
        end else if (w_count_nxt > r_high_water) begin
            r_high_water <= w_count_nxt;
        end
    end

    // RAM sequencing: write data passes straight through, head read is
    // combinational so the FIFO is show-ahead with no bypass path.
    assign bus.ram_wen   = w_push;
    assign bus.ram_waddr = w_wr_ptr[c_AW-1:0];
    assign bus.ram_wdata = bus.in_data;
    assign bus.ram_ren   = ~w_status.empty;
    assign bus.ram_raddr = w_rd_ptr[c_AW-1:0];
    assign w_head        = bus.ram_rdata;
    assign bus.out_data  = w_head;
    assign bus.in_ready  = ~w_status.full;
    assign bus.out_valid = ~w_status.empty;

    assign count        = r_count;
    assign high_water   = r_high_water;
    assign full         = w_status.full;
    assign empty        = w_status.empty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;

    // Occupancy must always equal the pointer distance modulo 2*SIZE.
    a_count_consistent: assert property (@(posedge clk) disable iff (rst)
        r_count == (w_wr_ptr - w_rd_ptr));

endmodule
`default_nettype wire

// File: tb/tb_d0fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d0fifo_ctrl
//  Description : Scoreboard bench for d0fifo_ctrl with a delay-0 RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d0fifo_ctrl;
    import d0fifo_pkg::*;

    localparam int c_WIDTH = 16;
    localparam int c_SIZE  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       hwm_clr;
    logic [3:0] count;
    logic [3:0] high_water;
    logic       full, empty, almost_full, almost_empty;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] sb[$];

    d0fifo_ctrl_if #(.WIDTH(c_WIDTH), .SIZE(c_SIZE)) bus ();

    d0fifo_ctrl #(
        .WIDTH    (c_WIDTH),
        .SIZE     (c_SIZE),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .hwm_clr      (hwm_clr),
        .bus          (bus),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .high_water   (high_water)
    );

    always #5 clk = ~clk;

    // Delay-0 RAM beside the controller.
    logic [15:0] mem [c_SIZE];
    always @(posedge clk) begin
        if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = mem[bus.ram_raddr];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pop handshake must present the oldest queued word.
    always @(negedge clk) begin
        if (!rst && !flush && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected none", bus.out_data);
            end else begin
                chk("pop_data", bus.out_data, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic acc);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        if (acc) sb.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_ae"}, almost_empty, 1);
        chk({tag, "_af"}, almost_full, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_hw"}, high_water, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hwm_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;

        // 1: single push, visible the next cycle
        drive(1'b1, 16'h0001, 1'b0, 1'b1);
        chk("t1_wen", bus.ram_wen, 1);
        chk("t1_waddr", bus.ram_waddr, 0);
        tick();
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_data", bus.out_data, 16'h0001);
        chk("t1_count", count, 1);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        chk("t1_empty", empty, 1);

        // 2: fill to full with consumer stalled
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'h10 + i), 1'b0, 1'b1);
            tick();
            chk("t2_count", count, i + 1);
            chk("t2_af", almost_full, (i + 1 >= 6) ? 1 : 0);
        end
        chk("t2_full", full, 1);
        chk("t2_in_ready", bus.in_ready, 0);
        chk("t2_ae", almost_empty, 0);
        drive(1'b1, 16'h0099, 1'b0, 1'b0);
        chk("t2_wen_blocked", bus.ram_wen, 0);
        chk("t2_waddr", bus.ram_waddr, 0);
        tick();
        chk("t2_count_hold", count, 8);
        chk("t2_hw", high_water, 8);

        // 3: push+pop while full -> pop only, then wrapped write
        drive(1'b1, 16'h00AA, 1'b1, 1'b0);
        tick();
        chk("t3_count", count, 7);
        chk("t3_out_data", bus.out_data, 16'h0011);
        chk("t3_full", full, 0);
        drive(1'b1, 16'h0018, 1'b0, 1'b1);
        chk("t3_wen", bus.ram_wen, 1);
        chk("t3_waddr_wrap", bus.ram_waddr, 0);
        tick();
        chk("t3_count_full", count, 8);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            tick();
        end
        chk("t3_drained", count, 0);

        // 4: steady state at count 3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h20 + i), 1'b0, 1'b1);
            tick();
        end
        chk("t4_count_start", count, 3);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(16'h23 + i), 1'b1, 1'b1);
            chk("t4_waddr", bus.ram_waddr, (3 + i) % 8);
            chk("t4_raddr", bus.ram_raddr, i % 8);
            tick();
            chk("t4_count", count, 3);
        end
        chk("t4_hw", high_water, 3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            tick();
        end

        // 5: flush at count 5 with a push pending
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'h30 + i), 1'b0, 1'b1);
            tick();
        end
        chk("t5_count_pre", count, 5);
        drive(1'b1, 16'h0055, 1'b1, 1'b0);
        flush = 1'b1;
        sb.delete();
        tick();
        flush = 1'b0;
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_hw", high_water, 5);
        chk("t5_out_valid", bus.out_valid, 0);
        drive(1'b1, 16'h0040, 1'b0, 1'b1);
        chk("t5_waddr", bus.ram_waddr, 0);
        tick();
        chk("t5_out_data", bus.out_data, 16'h0040);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        tick();

        // 6: hwm_clr after a peak of 8, then reset mid-stream
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'h50 + i), 1'b0, 1'b1);
            tick();
        end
        chk("t6_hw_peak", high_water, 8);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            tick();
        end
        chk("t6_count", count, 2);
        chk("t6_hw_held", high_water, 8);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        hwm_clr = 1'b1;
        tick();
        hwm_clr = 1'b0;
        chk("t6_hw_clr", high_water, 2);
        drive(1'b1, 16'h0060, 1'b1, 1'b0);
        rst = 1'b1;
        sb.delete();
        tick();
        chk_reset("t6_rst");
        rst = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
